// File: rtl/tts_pkg.sv
// Shared types and constants for the truth-table sweeper.
// The SWEEP_GRAY_EN macro selects Gray-code vector ordering in vec_of().
package tts_pkg;

  localparam int VEC_W = 4;
  localparam int N_VEC = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DONE  = 2'd2
  } state_e;

  // Maps the sweep index to the vector actually driven onto the DUT.
  function automatic logic [VEC_W-1:0] vec_of(input logic [VEC_W-1:0] idx);
`ifdef SWEEP_GRAY_EN
    return idx ^ (idx >> 1);
`else
    return idx;
`endif
  endfunction

endpackage

// File: rtl/sweep_dwell_timer.sv
// Dwell counter: counts while run is high and pulses tick on count DWELL-1,
// wrapping back to zero on the same edge. load clears it.
module sweep_dwell_timer #(
  parameter int DWELL = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  input  logic load,
  output logic tick
);

  localparam logic [7:0] LAST = 8'(DWELL - 1);

  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = '0;
    end else if (run) begin
      cnt_d = (cnt_q == LAST) ? 8'd0 : cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = run && !load && (cnt_q == LAST);

endmodule

// File: rtl/truth_table_sweeper.sv
// Drives all 16 input vectors into a 4-input combinational DUT, compares its
// response against EXPECTED and reports errors. SWEEP_GRAY_EN selects Gray order.
module truth_table_sweeper
  import tts_pkg::*;
#(
  parameter int          DWELL    = 4,
  parameter logic [15:0] EXPECTED = 16'h0000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic [VEC_W-1:0] abcd,
  input  logic             f_in,
  output logic             busy,
  output logic             done,
  output logic [4:0]       err_count,
  output logic             err_valid,
  output logic [VEC_W-1:0] first_err_idx
);

  state_e           state_q, state_d;
  logic [VEC_W-1:0] idx_q, idx_d;
  logic [4:0]       err_q, err_d;
  logic             valid_q, valid_d;
  logic [VEC_W-1:0] first_q, first_d;

  logic             run, load, tick, mismatch;
  logic [VEC_W-1:0] vec;

  assign vec      = vec_of(idx_q);
  assign run      = (state_q == SWEEP);
  // The expected bit is looked up by the driven vector, so ordering never changes results.
  assign mismatch = (f_in != EXPECTED[vec]);

  sweep_dwell_timer #(.DWELL(DWELL)) u_dwell (
    .clk   (clk),
    .rst_n (rst_n),
    .run   (run),
    .load  (load),
    .tick  (tick)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    err_d   = err_q;
    valid_d = valid_q;
    first_d = first_q;
    load    = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = SWEEP;
          idx_d   = '0;
          err_d   = '0;
          valid_d = 1'b0;
          first_d = '0;
          load    = 1'b1;
        end
      end
      SWEEP: begin
        if (tick) begin
          idx_d = idx_q + 4'd1;
          if (mismatch) begin
            if (err_q != 5'(N_VEC)) err_d = err_q + 5'd1;
            if (!valid_q) begin
              valid_d = 1'b1;
              first_d = vec;
            end
          end
          if (idx_q == 4'(N_VEC - 1)) state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      err_q   <= '0;
      valid_q <= 1'b0;
      first_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
      valid_q <= valid_d;
      first_q <= first_d;
    end
  end

  assign abcd          = run ? vec : '0;
  assign busy          = run;
  assign done          = (state_q == DONE);
  assign err_count     = err_q;
  assign err_valid     = valid_q;
  assign first_err_idx = first_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Directed bench: one sweeper with DWELL=4 and a modelled DUT with selectable
// faults, one with DWELL=1 and f_in tied high. Cycle 1 is the edge sampling start.
module tb_truth_table_sweeper;

  localparam logic [15:0] EXP_A = 16'hA5C3;

  logic        clk, rst_n;
  logic        start_a, start_b;
  logic [3:0]  abcd_a, abcd_b, first_a, first_b;
  logic        f_a, fb;
  logic        busy_a, busy_b, done_a, done_b, valid_a, valid_b;
  logic [4:0]  err_a, err_b;
  logic [15:0] flip_a;
  logic [3:0]  seq_a [16];
  logic [63:0] seq_tbl;

  int n_tot = 0;
  int n_bad = 0;
  int lat;

  assign f_a = EXP_A[abcd_a] ^ flip_a[abcd_a];

  truth_table_sweeper #(.DWELL(4), .EXPECTED(16'hA5C3)) u_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .abcd(abcd_a), .f_in(f_a),
    .busy(busy_a), .done(done_a), .err_count(err_a), .err_valid(valid_a),
    .first_err_idx(first_a)
  );

  truth_table_sweeper #(.DWELL(1), .EXPECTED(16'h0000)) u_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .abcd(abcd_b), .f_in(fb),
    .busy(busy_b), .done(done_b), .err_count(err_b), .err_valid(valid_b),
    .first_err_idx(first_b)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Pulses start, records the vector held in each dwell window, and returns the
  // cycle at which done was first seen (0 when it never came).
  task automatic sweep_a(input int mid_start, output int l);
    @(negedge clk);
    start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    l = 0;
    seq_a[0] = abcd_a;
    chk("busy_a_c1", 32'(busy_a), 32'd1);
    for (int c = 2; c <= 100; c++) begin
      @(posedge clk); #1;
      start_a = (c == mid_start);
      if (((c - 1) % 4 == 0) && c <= 61) seq_a[(c - 1) / 4] = abcd_a;
      if (done_a) begin
        l = c;
        break;
      end
    end
    start_a = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
`ifdef SWEEP_GRAY_EN
    seq_tbl = 64'h0132_6754_CDFE_AB98;
`else
    seq_tbl = 64'h0123_4567_89AB_CDEF;
`endif
    clk = 1'b0; rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0;
    flip_a = 16'h0000; fb = 1'b1;

    #12;
    chk("rst_busy_a",  32'(busy_a),  32'd0);
    chk("rst_done_a",  32'(done_a),  32'd0);
    chk("rst_abcd_a",  32'(abcd_a),  32'd0);
    chk("rst_err_a",   32'(err_a),   32'd0);
    chk("rst_valid_a", 32'(valid_a), 32'd0);
    chk("rst_first_a", 32'(first_a), 32'd0);
    chk("rst_busy_b",  32'(busy_b),  32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // DWELL=1, start held high, every vector mismatches
    @(negedge clk);
    start_b = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      if (c == 2)  chk("b_abcd_c2", 32'(abcd_b), 32'd1);
      if (c == 16) chk("b_done_c16", 32'(done_b), 32'd0);
      if (c == 17) begin
        chk("b_done_c17", 32'(done_b),  32'd1);
        chk("b_err16",    32'(err_b),   32'd16);
        chk("b_valid",    32'(valid_b), 32'd1);
        chk("b_first",    32'(first_b), 32'd0);
        chk("b_busy_dn",  32'(busy_b),  32'd0);
        chk("b_abcd_dn",  32'(abcd_b),  32'd0);
      end
      if (c == 18) begin
        chk("b_restart_busy",  32'(busy_b),  32'd1);
        chk("b_restart_done",  32'(done_b),  32'd0);
        chk("b_restart_err",   32'(err_b),   32'd0);
        chk("b_restart_valid", 32'(valid_b), 32'd0);
        break;
      end
    end
    @(negedge clk);
    start_b = 1'b0;

    // Clean sweep
    flip_a = 16'h0000;
    sweep_a(0, lat);
    chk("a1_lat",   32'(lat),     32'd65);
    chk("a1_err",   32'(err_a),   32'd0);
    chk("a1_valid", 32'(valid_a), 32'd0);
    chk("a1_busy",  32'(busy_a),  32'd0);
    chk("a1_abcd",  32'(abcd_a),  32'd0);
    for (int k = 0; k < 16; k++) begin
      logic [3:0] e;
      e = seq_tbl[63 - 4*k -: 4];
      chk($sformatf("a1_seq%0d", k), 32'(seq_a[k]), 32'(e));
    end
    repeat (3) @(posedge clk);
    #1;
    chk("a1_done_hold", 32'(done_a), 32'd1);

    // Faults on vectors 5 and 12, restarted from DONE
    flip_a = 16'h1020;
    sweep_a(0, lat);
    chk("a2_lat",   32'(lat),     32'd65);
    chk("a2_err",   32'(err_a),   32'd2);
    chk("a2_valid", 32'(valid_a), 32'd1);
    chk("a2_first", 32'(first_a), 32'd5);

    // Every vector wrong, with a stray start during the sweep
    flip_a = 16'hFFFF;
    sweep_a(20, lat);
    chk("a3_lat",   32'(lat),     32'd65);
    chk("a3_err",   32'(err_a),   32'd16);
    chk("a3_valid", 32'(valid_a), 32'd1);
    chk("a3_first", 32'(first_a), 32'd0);

    // Reset at cycle 30 aborts the sweep
    @(negedge clk);
    start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    repeat (29) @(posedge clk);
    #1;
    chk("a4_err_pre", 32'(err_a),  32'd7);
    chk("a4_busy_pre", 32'(busy_a), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("a4_busy",  32'(busy_a),  32'd0);
    chk("a4_done",  32'(done_a),  32'd0);
    chk("a4_abcd",  32'(abcd_a),  32'd0);
    chk("a4_err",   32'(err_a),   32'd0);
    chk("a4_valid", 32'(valid_a), 32'd0);
    chk("a4_first", 32'(first_a), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("a4_idle_busy", 32'(busy_a), 32'd0);
    chk("a4_idle_done", 32'(done_a), 32'd0);
    flip_a = 16'h0000;
    sweep_a(0, lat);
    chk("a4_lat", 32'(lat),   32'd65);
    chk("a4_err_post", 32'(err_a), 32'd0);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
